// File: rtl/pagerank_pkg.sv
// Shared constants and FSM encoding for the PageRank graph loader and its reciprocal divider.
// Weights are Q0.16 reciprocals of out-degree, derived from a 17-bit dividend of 2^16.
package pagerank_pkg;
    localparam int N       = 16;
    localparam int WIDTH   = 16;
    localparam int IDXW    = $clog2(N);
    localparam int DIV_LAT = WIDTH + 1;

    localparam logic [WIDTH:0]   BASE = 17'h10000;
    localparam logic [WIDTH-1:0] WSAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;
endpackage

// File: rtl/pagerank_graph_loader_if.sv
// Edge-stream input and graph output bundle between an edge source and the loader.
// The edge stream is valid/ready; graph outputs are level signals qualified by graph_valid.
interface pagerank_graph_loader_if #(
    parameter int N     = pagerank_pkg::N,
    parameter int WIDTH = pagerank_pkg::WIDTH
);
    import pagerank_pkg::*;
    localparam int IDXW = $clog2(N);
    localparam int ECW  = $clog2(N*N+1);

    logic              start;
    logic              edge_valid;
    logic              edge_ready;
    logic [IDXW-1:0]   edge_src;
    logic [IDXW-1:0]   edge_dst;
    logic              edge_last;
    logic [N*N-1:0]    adjacency;
    logic [N*WIDTH-1:0] weights;
    logic [ECW-1:0]    edge_count;
    logic              graph_valid;
    logic              pr_reset;

    modport master (
        output start, edge_valid, edge_src, edge_dst, edge_last,
        input  edge_ready, adjacency, weights, edge_count, graph_valid, pr_reset
    );

    modport slave (
        input  start, edge_valid, edge_src, edge_dst, edge_last,
        output edge_ready, adjacency, weights, edge_count, graph_valid, pr_reset
    );
endinterface

// File: rtl/pagerank_recip_div.sv
// Restoring divider, one quotient bit per cycle; the start cycle performs the first step.
// done pulses exactly LAT cycles after start; a new start abandons any division in flight.
module pagerank_recip_div import pagerank_pkg::*; #(
    parameter int DW  = IDXW + 1,
    parameter int NW  = WIDTH + 1,
    parameter int LAT = DIV_LAT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [NW-1:0] quotient
);
    localparam int CW = $clog2(LAT + 1);

    logic [DW-1:0] rem_q, dvs_q, src_rem, src_dvs, nxt_rem, diff;
    logic [NW-1:0] qr_q, src_qr, nxt_qr;
    logic [DW:0]   shifted;
    logic          ge;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;

    // qr holds the unconsumed dividend bits on top and the growing quotient below
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_qr  = start ? dividend : qr_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_qr[NW-1]};
        ge      = shifted >= {1'b0, src_dvs};
        diff    = shifted[DW-1:0] - src_dvs;
        nxt_rem = ge ? diff : shifted[DW-1:0];
        nxt_qr  = {src_qr[NW-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            qr_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= nxt_rem;
                qr_q   <= nxt_qr;
                dvs_q  <= divisor;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= nxt_rem;
                qr_q  <= nxt_qr;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(LAT - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done     = done_q;
    assign quotient = qr_q;
endmodule

// File: rtl/pagerank_graph_loader.sv
// Builds adjacency and 1/out-degree weights from an edge stream, then holds them with graph_valid.
// edge_ready is high for the whole LOAD phase; weights take N*(DIV_LAT+1) cycles after the last edge.
module pagerank_graph_loader #(
    parameter int N     = pagerank_pkg::N,
    parameter int WIDTH = pagerank_pkg::WIDTH
) (
    input logic                    clk,
    input logic                    reset_n,
    pagerank_graph_loader_if.slave bus
);
    import pagerank_pkg::*;
    localparam int IDXW = $clog2(N);
    localparam int DEGW = IDXW + 1;
    localparam int ECW  = $clog2(N*N+1);

    state_t             state_q, state_d;
    logic [N*N-1:0]     adj_q;
    logic [N*WIDTH-1:0] wgt_q;
    logic [ECW-1:0]     cnt_q;
    logic [DEGW-1:0]    outdeg_q [N];
    logic [IDXW-1:0]    node_q;
    logic               waiting_q, gv_q;

    logic               hs, edge_new, div_start, div_done, node_wr, last_node;
    logic [WIDTH:0]     div_q;
    logic [DEGW-1:0]    cur_deg;
    logic [WIDTH-1:0]   wgt_new;
    int                 adj_idx;

    always_comb begin
        adj_idx   = int'(bus.edge_dst) * N + int'(bus.edge_src);
        hs        = bus.edge_valid && (state_q == LOAD);
        edge_new  = hs && (bus.edge_src != bus.edge_dst) &&
                    (int'(bus.edge_src) < N) && (int'(bus.edge_dst) < N) && !adj_q[adj_idx];
        cur_deg   = outdeg_q[node_q];
        div_start = (state_q == CALC) && !waiting_q;
        node_wr   = (state_q == CALC) && waiting_q && div_done;
        last_node = node_q == IDXW'(N - 1);
        // a zero divisor yields garbage from the divider, so dangling nodes are forced to 0
        if (cur_deg == '0)
            wgt_new = '0;
        else if (div_q > {1'b0, WSAT})
            wgt_new = WSAT;
        else
            wgt_new = div_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                LOAD:    if (hs && bus.edge_last) state_d = CALC;
                CALC:    if (node_wr && last_node) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // start has priority over a same-cycle edge beat, which is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adj_q     <= '0;
            wgt_q     <= '0;
            cnt_q     <= '0;
            node_q    <= '0;
            waiting_q <= 1'b0;
            gv_q      <= 1'b0;
            for (int k = 0; k < N; k++) outdeg_q[k] <= '0;
        end else if (bus.start) begin
            adj_q     <= '0;
            wgt_q     <= '0;
            cnt_q     <= '0;
            node_q    <= '0;
            waiting_q <= 1'b0;
            gv_q      <= 1'b0;
            for (int k = 0; k < N; k++) outdeg_q[k] <= '0;
        end else begin
            if (edge_new) begin
                adj_q[adj_idx]         <= 1'b1;
                outdeg_q[bus.edge_src] <= outdeg_q[bus.edge_src] + 1'b1;
                cnt_q                  <= cnt_q + 1'b1;
            end
            if (div_start) waiting_q <= 1'b1;
            if (node_wr) begin
                wgt_q[int'(node_q)*WIDTH +: WIDTH] <= wgt_new;
                waiting_q <= 1'b0;
                node_q    <= node_q + 1'b1;
                if (last_node) gv_q <= 1'b1;
            end
        end
    end

    pagerank_recip_div #(
        .DW  (DEGW),
        .NW  (WIDTH + 1),
        .LAT (WIDTH + 1)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (BASE),
        .divisor  (cur_deg),
        .done     (div_done),
        .quotient (div_q)
    );

    assign bus.edge_ready  = (state_q == LOAD);
    assign bus.adjacency   = adj_q;
    assign bus.weights     = wgt_q;
    assign bus.edge_count  = cnt_q;
    assign bus.graph_valid = gv_q;
    assign bus.pr_reset    = !gv_q;
endmodule

// File: tb/tb_pagerank_graph_loader.sv
// Directed bench for the graph loader: an N=4 instance for graph content, an N=16 one for timing.
// Expected graphs are queued at stimulus time and compared when graph_valid rises.
module tb_pagerank_graph_loader;
    typedef struct {
        logic [255:0] adj;
        logic [255:0] w;
        logic [8:0]   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q4[$];
    exp_t q16[$];
    logic gv4_prev = 1'b0;
    logic gv16_prev = 1'b0;

    int g1_s[8] = '{0, 0, 0, 1, 1, 2, 3, 3};
    int g1_d[8] = '{1, 2, 3, 2, 3, 0, 0, 2};

    always #5 clk = ~clk;

    pagerank_graph_loader_if #(.N(4),  .WIDTH(16)) bus4 ();
    pagerank_graph_loader_if #(.N(16), .WIDTH(16)) bus16 ();

    pagerank_graph_loader #(.N(4),  .WIDTH(16)) dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));
    pagerank_graph_loader #(.N(16), .WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16.slave));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic send(input bit big, input int s, input int d, input bit last);
        if (big) begin
            bus16.edge_valid = 1'b1; bus16.edge_src = 4'(s); bus16.edge_dst = 4'(d); bus16.edge_last = last;
        end else begin
            bus4.edge_valid = 1'b1; bus4.edge_src = 2'(s); bus4.edge_dst = 2'(d); bus4.edge_last = last;
        end
        @(posedge clk); #1;
        bus16.edge_valid = 1'b0; bus16.edge_last = 1'b0;
        bus4.edge_valid  = 1'b0; bus4.edge_last  = 1'b0;
    endtask

    task automatic pulse_start(input bit big);
        if (big) bus16.start = 1'b1; else bus4.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus4.start = 1'b0;
    endtask

    task automatic load_graph1(input bit big);
        for (int i = 0; i < 8; i++) send(big, g1_s[i], g1_d[i], i == 7);
    endtask

    task automatic wait_gv(input bit big, input int budget, output int n);
        logic gv;
        n = 0;
        gv = 1'b0;
        while (n < budget && !gv) begin
            @(posedge clk); #1;
            n++;
            gv = big ? bus16.graph_valid : bus4.graph_valid;
        end
        if (!gv) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_gv: graph_valid still %0b after %0d cycles, expected 1", gv, n);
        end
    endtask

    // scoreboard monitors: compare the final graph whenever graph_valid rises
    always @(negedge clk) begin
        exp_t e;
        if (bus4.graph_valid && !gv4_prev) begin
            if (q4.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb4_unexpected: got graph_valid=1, expected no graph pending");
            end else begin
                e = q4.pop_front();
                chk("sb4_adjacency", 256'(bus4.adjacency), e.adj);
                chk("sb4_weights", 256'(bus4.weights), e.w);
                chk("sb4_edge_count", 256'(bus4.edge_count), 256'(e.cnt));
                chk("sb4_pr_reset", 256'(bus4.pr_reset), 256'(0));
            end
        end
        gv4_prev <= bus4.graph_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus16.graph_valid && !gv16_prev) begin
            if (q16.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb16_unexpected: got graph_valid=1, expected no graph pending");
            end else begin
                e = q16.pop_front();
                chk("sb16_adjacency", 256'(bus16.adjacency), e.adj);
                chk("sb16_weights", 256'(bus16.weights), e.w);
                chk("sb16_edge_count", 256'(bus16.edge_count), 256'(e.cnt));
                chk("sb16_pr_reset", 256'(bus16.pr_reset), 256'(0));
            end
        end
        gv16_prev <= bus16.graph_valid;
    end

    initial begin
        int n;
        bus4.start = 1'b0;  bus4.edge_valid = 1'b0;  bus4.edge_src = '0;  bus4.edge_dst = '0;  bus4.edge_last = 1'b0;
        bus16.start = 1'b0; bus16.edge_valid = 1'b0; bus16.edge_src = '0; bus16.edge_dst = '0; bus16.edge_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset state
        chk("rst_graph_valid", 256'(bus4.graph_valid), 256'(0));
        chk("rst_pr_reset", 256'(bus4.pr_reset), 256'(1));
        chk("rst_edge_ready", 256'(bus4.edge_ready), 256'(0));
        chk("rst_edge_count", 256'(bus4.edge_count), 256'(0));
        chk("rst_adjacency", 256'(bus4.adjacency), 256'(0));
        chk("rst_weights", 256'(bus4.weights), 256'(0));
        chk("rst16_pr_reset", 256'(bus16.pr_reset), 256'(1));

        // test 1: full N=4 graph
        q4.push_back('{adj: 256'h3B1C, w: 256'h8000_FFFF_8000_5555, cnt: 9'd8});
        pulse_start(1'b0);
        chk("t1_edge_ready_load", 256'(bus4.edge_ready), 256'(1));
        load_graph1(1'b0);
        chk("t1_edge_ready_calc", 256'(bus4.edge_ready), 256'(0));
        wait_gv(1'b0, 200, n);

        // test 2: duplicates and self-loop filtered
        q4.push_back('{adj: 256'h0012, w: 256'h0000_0000_FFFF_FFFF, cnt: 9'd2});
        pulse_start(1'b0);
        send(1'b0, 0, 1, 1'b0);
        send(1'b0, 0, 1, 1'b0);
        send(1'b0, 2, 2, 1'b0);
        send(1'b0, 1, 0, 1'b1);
        wait_gv(1'b0, 200, n);
        chk("t2_bit10", 256'(bus4.adjacency[10]), 256'(0));

        // test 3: N=16 CALC latency and DONE hold
        q16.push_back('{adj: (256'h0020 << 240) | 256'h0001_0001_0000,
                        w: (256'hFFFF << 80) | 256'h8000, cnt: 9'd3});
        pulse_start(1'b1);
        send(1'b1, 0, 1, 1'b0);
        send(1'b1, 0, 2, 1'b0);
        send(1'b1, 5, 15, 1'b1);
        wait_gv(1'b1, 400, n);
        chk("t3_latency", 256'(n), 256'(288));
        chk("t3_pr_reset", 256'(bus16.pr_reset), 256'(0));
        bus16.edge_valid = 1'b1; bus16.edge_src = 4'd3; bus16.edge_dst = 4'd4;
        repeat (5) @(posedge clk);
        #1;
        chk("t3_done_edge_ready", 256'(bus16.edge_ready), 256'(0));
        chk("t3_done_edge_count", 256'(bus16.edge_count), 256'(3));
        chk("t3_done_adjacency", 256'(bus16.adjacency), (256'h0020 << 240) | 256'h0001_0001_0000);
        chk("t3_done_graph_valid", 256'(bus16.graph_valid), 256'(1));
        bus16.edge_valid = 1'b0;

        // test 4: restart mid-CALC then reload the same graph
        pulse_start(1'b1);
        load_graph1(1'b1);
        repeat (100) @(posedge clk);
        #1;
        chk("t4_midcalc_graph_valid", 256'(bus16.graph_valid), 256'(0));
        pulse_start(1'b1);
        chk("t4_clr_edge_ready", 256'(bus16.edge_ready), 256'(1));
        chk("t4_clr_edge_count", 256'(bus16.edge_count), 256'(0));
        chk("t4_clr_adjacency", 256'(bus16.adjacency), 256'(0));
        chk("t4_clr_weights", 256'(bus16.weights), 256'(0));
        chk("t4_clr_graph_valid", 256'(bus16.graph_valid), 256'(0));
        chk("t4_clr_pr_reset", 256'(bus16.pr_reset), 256'(1));
        q16.push_back('{adj: 256'h0003_000B_0001_000C, w: 256'h8000_FFFF_8000_5555, cnt: 9'd8});
        load_graph1(1'b1);
        wait_gv(1'b1, 400, n);

        // test 5: reset pulse mid-LOAD
        pulse_start(1'b0);
        send(1'b0, 0, 1, 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("t5_edge_ready", 256'(bus4.edge_ready), 256'(0));
        chk("t5_edge_count", 256'(bus4.edge_count), 256'(0));
        chk("t5_adjacency", 256'(bus4.adjacency), 256'(0));
        chk("t5_graph_valid", 256'(bus4.graph_valid), 256'(0));
        chk("t5_pr_reset", 256'(bus4.pr_reset), 256'(1));
        send(1'b0, 1, 2, 1'b0);
        send(1'b0, 3, 0, 1'b1);
        chk("t5_idle_edge_count", 256'(bus4.edge_count), 256'(0));
        chk("t5_idle_adjacency", 256'(bus4.adjacency), 256'(0));

        // test 6: start and an edge beat in the same LOAD cycle
        pulse_start(1'b0);
        bus4.start = 1'b1; bus4.edge_valid = 1'b1; bus4.edge_src = 2'd0; bus4.edge_dst = 2'd1;
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.edge_valid = 1'b0;
        chk("t6_edge_count", 256'(bus4.edge_count), 256'(0));
        chk("t6_adjacency", 256'(bus4.adjacency), 256'(0));
        chk("t6_edge_ready", 256'(bus4.edge_ready), 256'(1));
        q4.push_back('{adj: 256'h4000, w: 256'h0000_FFFF_0000_0000, cnt: 9'd1});
        send(1'b0, 2, 3, 1'b1);
        wait_gv(1'b0, 200, n);

        repeat (3) @(posedge clk);
        #1;
        chk("sb4_drained", 256'(q4.size()), 256'(0));
        chk("sb16_drained", 256'(q16.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
